// File: rtl/hilo_acc_unit.sv
// HI/LO register pair with direct writes and a multi-cycle result path that
// loads, accumulates into, or subtracts from the 2W-bit {HI,LO} value.
module hilo_acc_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   wen,
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] lo_i,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic         res_valid,
    input  logic [W-1:0] res_hi,
    input  logic [W-1:0] res_lo,
    input  logic         flush,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o,
    output logic         busy,
    output logic         stall,
    output logic         done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic [1:0]     op_q;
    logic           done_q;
    logic [2*W-1:0] p;
    logic [2*W-1:0] r;
    logic [2*W-1:0] p_next;
    logic           commit;

    assign p      = {hi_q, lo_q};
    assign r      = {res_hi, res_lo};
    // flush outranks res_valid, so a killed operation never commits
    assign commit = (state == S_WAIT) & res_valid & ~flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_WAIT;
            S_WAIT: if (flush || res_valid) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state == S_WAIT);
        stall = busy & (start | (wen != 2'b00)) & ~(res_valid & ~flush);
    end

    // Full-width arithmetic lets LO's carry/borrow ripple into HI
    always_comb begin
        p_next = p;
        case (op_q)
            2'b00:   p_next = r;
            2'b01:   p_next = p + r;
            2'b10:   p_next = p - r;
            default: p_next = p;
        endcase
    end

    // Direct writes and issue capture only happen in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            op_q   <= 2'b00;
            done_q <= 1'b0;
        end else begin
            done_q <= commit;
            if (commit) begin
                {hi_q, lo_q} <= p_next;
            end else if (state == S_IDLE) begin
                if (wen[1]) hi_q <= hi_i;
                if (wen[0]) lo_q <= lo_i;
                if (start)  op_q <= op;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Bench for hilo_acc_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_hilo_acc_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   wen;
    logic [W-1:0] hi_i, lo_i;
    logic         start;
    logic [1:0]   op;
    logic         res_valid;
    logic [W-1:0] res_hi, res_lo;
    logic         flush;
    logic [W-1:0] hi_o, lo_o;
    logic         busy, stall, done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // behavioural model state
    logic [2*W-1:0] m_p    = '0;
    bit             m_busy = 1'b0;
    logic [1:0]     m_op   = 2'b00;
    bit             m_done = 1'b0;

    hilo_acc_unit #(.W(W)) dut (
        .clk(clk), .rst(rst), .wen(wen), .hi_i(hi_i), .lo_i(lo_i),
        .start(start), .op(op), .res_valid(res_valid), .res_hi(res_hi),
        .res_lo(res_lo), .flush(flush), .hi_o(hi_o), .lo_o(lo_o),
        .busy(busy), .stall(stall), .done(done)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model update on each active edge from the inputs held during that cycle
    always @(posedge clk) begin
        if (rst) begin
            m_p = '0; m_busy = 1'b0; m_op = 2'b00; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (wen[1]) m_p[2*W-1:W] = hi_i;
                if (wen[0]) m_p[W-1:0]   = lo_i;
                if (start) begin
                    m_busy = 1'b1;
                    m_op   = op;
                end
            end else if (flush) begin
                m_busy = 1'b0;
            end else if (res_valid) begin
                case (m_op)
                    2'b00:   m_p = {res_hi, res_lo};
                    2'b01:   m_p = m_p + {res_hi, res_lo};
                    2'b10:   m_p = m_p - {res_hi, res_lo};
                    default: m_p = m_p;
                endcase
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hi_o",  {{W{1'b0}}, hi_o}, {{W{1'b0}}, m_p[2*W-1:W]});
            chk("lo_o",  {{W{1'b0}}, lo_o}, {{W{1'b0}}, m_p[W-1:0]});
            chk("busy",  {63'd0, busy}, {63'd0, m_busy});
            chk("done",  {63'd0, done}, {63'd0, m_done});
            chk("stall", {63'd0, stall},
                {63'd0, m_busy && (start || wen != 2'b00) && !(res_valid && !flush)});
        end
    end

    // driver tasks
    task automatic idle_in();
        rst = 1'b0; wen = 2'b00; hi_i = '0; lo_i = '0; start = 1'b0; op = 2'b00;
        res_valid = 1'b0; res_hi = '0; res_lo = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] w, input logic [W-1:0] h, input logic [W-1:0] l);
        idle_in(); wen = w; hi_i = h; lo_i = l; tick();
    endtask

    task automatic do_start(input logic [1:0] o);
        idle_in(); start = 1'b1; op = o; tick();
    endtask

    task automatic do_result(input logic [W-1:0] h, input logic [W-1:0] l);
        idle_in(); res_valid = 1'b1; res_hi = h; res_lo = l; tick();
    endtask

    task automatic pin(input string name, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic eb, input logic ed);
        chk({name, "_hi"},   {{W{1'b0}}, hi_o}, {{W{1'b0}}, eh});
        chk({name, "_lo"},   {{W{1'b0}}, lo_o}, {{W{1'b0}}, el});
        chk({name, "_busy"}, {63'd0, busy}, {63'd0, eb});
        chk({name, "_done"}, {63'd0, done}, {63'd0, ed});
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        pin("reset", 32'h0, 32'h0, 1'b0, 1'b0);

        do_write(2'b11, 32'h1111_1111, 32'h2222_2222);
        pin("wr_both", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        do_write(2'b01, 32'h0, 32'h5);
        pin("wr_lo", 32'h1111_1111, 32'h5, 1'b0, 1'b0);

        do_start(2'b00);
        pin("load_issue", 32'h1111_1111, 32'h5, 1'b1, 1'b0);
        idle_in(); tick(); tick(); tick();
        do_result(32'h1, 32'hFFFF_FFFF);
        pin("load_commit", 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        idle_in(); tick();
        pin("load_after", 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        do_write(2'b10, 32'h0, 32'h0);
        do_start(2'b01);
        do_result(32'h0, 32'h1);
        pin("madd_carry", 32'h1, 32'h0, 1'b0, 1'b1);

        do_write(2'b11, 32'h0, 32'h0);
        do_start(2'b10);
        do_result(32'h0, 32'h1);
        pin("msub_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);

        do_start(2'b00);
        idle_in(); wen = 2'b10; hi_i = 32'hDEAD_BEEF;
        #1;
        chk("conflict_stall", {63'd0, stall}, 64'd1);
        tick();
        pin("conflict_hold", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle_in(); flush = 1'b1; res_valid = 1'b1; res_hi = 32'h1234; res_lo = 32'h5678; tick();
        pin("flush_wins", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

        do_start(2'b01);
        idle_in(); rst = 1'b1; res_valid = 1'b1; res_hi = 32'h7; res_lo = 32'h9; tick();
        pin("rst_mid_op", 32'h0, 32'h0, 1'b0, 1'b0);

        idle_in(); flush = 1'b1; start = 1'b1; op = 2'b11; tick();
        pin("flush_idle_start", 32'h0, 32'h0, 1'b1, 1'b0);
        do_result(32'hAAAA, 32'hBBBB);
        pin("op11_keep", 32'h0, 32'h0, 1'b0, 1'b1);

        // randomized traffic, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            wen       = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hi_i      = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
            lo_i      = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            op        = 2'($urandom_range(0, 3));
            res_valid = ($urandom_range(0, 3) == 0);
            res_hi    = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
            res_lo    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
            flush     = ($urandom_range(0, 9) == 0);
            tick();
        end
        idle_in();
        tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_acc_unit.md
HILO_ACC_UNIT -- requirements
Module: hilo_acc_unit

Interface
REQ-001 SHALL have parameter W, default 32, giving the width of HI and of LO in bits.
REQ-002 SHALL have reset rst, synchronous, active-high, and clock clk.
REQ-003 SHALL have ports, in this order:
  clk  in  1  clock
  rst  in  1  sync active-high reset
  wen  in  2  direct write enables: [1]=HI (MTHI), [0]=LO (MTLO)
  hi_i  in  W  direct HI write data
  lo_i  in  W  direct LO write data
  start  in  1  multi-cycle mult/div issued this cycle
  op  in  2  result mode, sampled with start: 00 load, 01 accumulate (MADD), 10 subtract (MSUB), 11 reserved
  res_valid  in  1  multi-cycle result present this cycle
  res_hi  in  W  result upper half
  res_lo  in  W  result lower half
  flush  in  1  cancel outstanding operation (exception/branch kill)
  hi_o  out  W  HI register
  lo_o  out  W  LO register
  busy  out  1  operation outstanding
  stall  out  1  issue conflict, upstream must hold
  done  out  1  one-cycle commit pulse

Function
REQ-004 SHALL implement two states: IDLE and WAIT, with busy=1 exactly in WAIT.
REQ-005 IDLE with start=1 SHALL capture op and enter WAIT on the next edge.
REQ-006 WAIT with flush=1 SHALL return to IDLE with no change to HI/LO and done=0.
REQ-007 WAIT with res_valid=1 and flush=0 SHALL commit and return to IDLE.
REQ-008 Commit SHALL act on the 2W-bit value P={hi,lo} and R={res_hi,res_lo}.
  - Op 00: P<=R.
  - Op 01: P<=P+R.
  - Op 10: P<=P-R.
  - Op 11: P unchanged, with the normal return to IDLE.
REQ-009 Accumulate/subtract SHALL be modulo 2^(2W), with the carry/borrow from LO propagating into HI, and no overflow flag.
REQ-010 done SHALL be registered, high for exactly the one cycle after the commit edge, concurrently with the updated hi_o/lo_o.
REQ-011 hi_o/lo_o SHALL be registered outputs with no bypass, so a write at edge N is visible from cycle N+1.
REQ-012 In IDLE, wen[1]/wen[0] SHALL independently write hi_i/lo_i; both bits set writes both.
REQ-013 In IDLE, wen and start in the same cycle SHALL both take effect: the direct write applies and op is captured.
REQ-014 stall SHALL be combinational, equal to busy & (start | (wen!=0)) & ~(res_valid & ~flush).
REQ-015 While stall=1, wen and start SHALL be ignored, with the requester holding them.
REQ-016 In the WAIT cycle where the commit occurs, wen and start SHALL be ignored; upstream re-presents them in the following IDLE cycle.
REQ-017 res_valid in IDLE SHALL be ignored.
REQ-018 flush in IDLE SHALL have no effect, and a start in that same cycle still enters WAIT.
REQ-019 flush and res_valid in the same WAIT cycle SHALL resolve as flush wins, with no commit.

Reset
REQ-020 rst SHALL take priority over all inputs and take effect at the next clk edge.
REQ-021 Reset SHALL set state=IDLE, HI=0, LO=0, the captured op to 00, and done=0, so busy=0 and stall=0.
REQ-022 rst during WAIT SHALL discard the outstanding operation, and a res_valid in that cycle SHALL not commit.

Verification (W=32)
REQ-023 Direct write: wen=11, hi_i=0x1111_1111, lo_i=0x2222_2222 in IDLE -> next cycle hi_o=0x11111111, lo_o=0x22222222; wen=01, lo_i=5 -> lo_o=5, hi_o unchanged.
REQ-024 Load: start, op=00; 3 cycles later res_valid, R=0x00000001_FFFFFFFF -> hi_o=1, lo_o=0xFFFFFFFF, done pulses once, busy falls.
REQ-025 MADD carry: P=0x00000000_FFFFFFFF, start op=01, R=1 -> hi_o=1, lo_o=0.
REQ-026 MSUB wrap: P=0, start op=10, R=1 -> hi_o=lo_o=0xFFFFFFFF.
REQ-027 Conflict: in WAIT, wen=10 with no res_valid -> stall=1 and HI unchanged; flush+res_valid same cycle -> no commit, done=0, IDLE.
REQ-028 Reset mid-op: rst asserted in WAIT with res_valid=1 -> hi_o=lo_o=0, busy=0, done=0.
